led_shift_datapath: RTL and testbench
=====================================

Name: led_shift_datapath

Overview:
- 8-bit LED-pattern datapath with three stages.
- Stage 1: a seed multiplexer chooses between two constant patterns.
- Stage 2: a feedback multiplexer chooses between that seed and the current register value.
- Stage 3: a combinational shifter/rotator feeds a loadable register with asynchronous clear.
- Used as a "walking LED" generator: load a seed once, then recirculate through the rotator every clock.

Parameters:
- WIDTH, 8: datapath and LED width.
- SEED_A, 8'b1000_0000: pattern selected when sel_seed=0.
- SEED_B, 8'b0000_0001: pattern selected when sel_seed=1.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset; forces led to 0.
- load  input  1  register load enable, synchronous, sampled on the rising edge of clk.
- sel_seed  input  1  seed mux select: 0 = SEED_A, 1 = SEED_B.
- sel_feedback  input  1  feedback mux select: 0 = seed mux output, 1 = current led value.
- func  input  2  shifter operation (encoding under Behaviour).
- led  output  WIDTH  register contents.

Behaviour:
- Datapath:
  - seed = sel_seed ? SEED_B : SEED_A.
  - src = sel_feedback ? led : seed.
  - nxt = shift(func, src).
  - All three are purely combinational with no latches; every select value drives a defined output.
- func encoding:
  - 2'b00 PASS: nxt = src.
  - 2'b01 SHL: logical shift left by 1, zero fill; MSB discarded.
  - 2'b10 SHR: logical shift right by 1, zero fill; LSB discarded.
  - 2'b11 ROR: rotate right by 1; bit 0 wraps into bit WIDTH-1.
- Register:
  - clear=1: led = 0 immediately, independent of clk; held at 0 while clear is asserted.
  - On rising clk edge with clear=0, load=1: led <= nxt.
  - load=0: led holds its value.
  - clear has priority over load. Deasserting clear takes effect at the next clock edge.
- Latency: one clock from inputs to led; no pipeline stages beyond the register.
- Reset value: led = 8'h00.
- Boundaries:
  - ROR of 8'h01 gives 8'h80 (wrap-around).
  - SHL of 8'h80 gives 8'h00; SHR of 8'h01 gives 8'h00.
  - ROR of 8'h00 stays 8'h00, so recirculating after clear without a seed load stays dark. This is intended; a seed must be loaded first.
  - func and select changes between edges have no effect until the next edge.

Decomposition:
- Package led_shift_pkg holds:
  - typedef enum logic [1:0] shift_func_t {FUNC_PASS, FUNC_SHL, FUNC_SHR, FUNC_ROR}.
  - Default seed constants SEED_A_DEF and SEED_B_DEF.
- One natural sub-module: bit_shifter, parameterised by WIDTH, inputs func and data, output result, purely combinational.
- The muxes and the register stay inline in led_shift_datapath.

Test Plan:
- Reset: clear=1, load=1, arbitrary clocks -> led=8'h00 throughout. Assert clear mid-sequence asynchronously (between edges) -> led=8'h00 before the next edge.
- Seed load: clear=0, sel_seed=0, sel_feedback=0, func=PASS, one edge -> led=8'h80. With sel_seed=1 -> led=8'h01.
- Walking LED:
  - After loading 8'h80, set sel_feedback=1, func=ROR.
  - Successive edges -> 8'h40, 20, 10, 08, 04, 02, 01, then 8'h80 (wrap).
  - Continue 16+ cycles to check periodicity of 8.
- Shift-out: load 8'h80, then feedback with SHR -> 40, 20, ..., 01, 00, 00. Load 8'h01, feedback with SHL -> 02, ..., 80, 00.
- Hold: led=8'h10, load=0, func=ROR, feedback on, 5 edges -> led stays 8'h10. Re-assert load -> 8'h08 on the next edge.
- Priority: clear=1 and load=1 with nxt≠0 on the same edge -> led=8'h00.

Source files
------------

// File: rtl/led_shift_pkg.sv
// Shared types and default seed patterns for the walking-LED datapath.
package led_shift_pkg;

   typedef enum logic [1:0] {
      FUNC_PASS = 2'b00,
      FUNC_SHL  = 2'b01,
      FUNC_SHR  = 2'b10,
      FUNC_ROR  = 2'b11
   } shift_func_t;

   localparam logic [7:0] SEED_A_DEF = 8'b1000_0000;
   localparam logic [7:0] SEED_B_DEF = 8'b0000_0001;

endpackage

// File: rtl/led_shift_datapath_bit_shifter.sv
// Combinational one-bit shifter/rotator: pass, shift left, shift right, rotate right.
module bit_shifter
   import led_shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       func,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] result
);

   shift_func_t w_func;

   assign w_func = shift_func_t'(func);

   always_comb begin
      result = data;
      case (w_func)
         FUNC_PASS: result = data;
         FUNC_SHL:  result = {data[WIDTH-2:0], 1'b0};
         FUNC_SHR:  result = {1'b0, data[WIDTH-1:1]};
         FUNC_ROR:  result = {data[0], data[WIDTH-1:1]};
         default:   result = data;
      endcase
   end

endmodule

// File: rtl/led_shift_datapath.sv
// Walking-LED datapath: seed mux -> feedback mux -> shifter -> loadable register with async clear.
module led_shift_datapath
   import led_shift_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] SEED_A = SEED_A_DEF,
   parameter logic [WIDTH-1:0] SEED_B = SEED_B_DEF
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic             sel_seed,
   input  logic             sel_feedback,
   input  logic [1:0]       func,
   output logic [WIDTH-1:0] led
);

   logic [WIDTH-1:0] r_led;
   logic [WIDTH-1:0] w_seed;
   logic [WIDTH-1:0] w_src;
   logic [WIDTH-1:0] w_nxt;

   assign w_seed = sel_seed ? SEED_B : SEED_A;
   assign w_src  = sel_feedback ? r_led : w_seed;

   bit_shifter #(
      .WIDTH (WIDTH)
   ) u_bit_shifter (
      .func   (func),
      .data   (w_src),
      .result (w_nxt)
   );

   // clear dominates load; an all-zero register recirculates as zero until a seed is loaded
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_led <= '0;
      end else if (load) begin
         r_led <= w_nxt;
      end
   end

   assign led = r_led;

endmodule

// File: tb/tb_led_shift_datapath.sv
// Scoreboard bench for led_shift_datapath: expected LED values queued per edge, compared after it.
module tb_led_shift_datapath;

   logic       clk = 1'b0;
   logic       clear;
   logic       load;
   logic       sel_seed;
   logic       sel_feedback;
   logic [1:0] func;
   logic [7:0] led;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   logic [7:0] walk_t[8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
   logic [7:0] shr_t[9]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'h00};
   logic [7:0] shl_t[8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};

   led_shift_datapath #(
      .WIDTH  (8),
      .SEED_A (8'b1000_0000),
      .SEED_B (8'b0000_0001)
   ) dut (
      .clk          (clk),
      .clear        (clear),
      .load         (load),
      .sel_seed     (sel_seed),
      .sel_feedback (sel_feedback),
      .func         (func),
      .led          (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic edge_chk(input string tag, input logic [7:0] e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      chk(tag, led, exp_q.pop_front());
   endtask

   task automatic drive(input logic ld, input logic ss, input logic fb, input logic [1:0] f);
      load         = ld;
      sel_seed     = ss;
      sel_feedback = fb;
      func         = f;
   endtask

   initial begin
      clear = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 2'b00);
      #2;
      chk("rst_async", led, 8'h00);
      for (int i = 0; i < 3; i++) edge_chk("rst_hold", 8'h00);

      clear = 1'b0;
      edge_chk("seed_a", 8'h80);
      drive(1'b1, 1'b1, 1'b0, 2'b00);
      edge_chk("seed_b", 8'h01);

      drive(1'b1, 1'b0, 1'b0, 2'b00);
      edge_chk("walk_seed", 8'h80);
      drive(1'b1, 1'b0, 1'b1, 2'b11);
      for (int i = 0; i < 24; i++) edge_chk("walk_ror", walk_t[i % 8]);

      #2;
      clear = 1'b1;
      #1;
      chk("clr_mid", led, 8'h00);
      edge_chk("clr_held", 8'h00);
      clear = 1'b0;
      edge_chk("dark_ror", 8'h00);

      drive(1'b1, 1'b0, 1'b0, 2'b00);
      edge_chk("shr_seed", 8'h80);
      drive(1'b1, 1'b0, 1'b1, 2'b10);
      for (int i = 0; i < 9; i++) edge_chk("shr_out", shr_t[i]);

      drive(1'b1, 1'b1, 1'b0, 2'b00);
      edge_chk("shl_seed", 8'h01);
      drive(1'b1, 1'b1, 1'b1, 2'b01);
      for (int i = 0; i < 8; i++) edge_chk("shl_out", shl_t[i]);

      drive(1'b1, 1'b0, 1'b0, 2'b00);
      edge_chk("hold_seed", 8'h80);
      drive(1'b1, 1'b0, 1'b1, 2'b11);
      edge_chk("hold_pre", 8'h40);
      edge_chk("hold_pre", 8'h20);
      edge_chk("hold_pre", 8'h10);
      drive(1'b0, 1'b0, 1'b1, 2'b11);
      for (int i = 0; i < 5; i++) edge_chk("hold", 8'h10);
      drive(1'b1, 1'b0, 1'b1, 2'b11);
      edge_chk("hold_reload", 8'h08);

      drive(1'b1, 1'b0, 1'b0, 2'b00);
      clear = 1'b1;
      edge_chk("prio_clr", 8'h00);
      clear = 1'b0;
      edge_chk("clr_release", 8'h80);

      drive(1'b1, 1'b1, 1'b0, 2'b01);
      #2;
      drive(1'b1, 1'b0, 1'b1, 2'b11);
      edge_chk("late_sel", 8'h40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

endmodule
